// File: rtl/mod3_stream_sched.sv
// mod3_stream_sched
//   Round-robin scheduler and sequencer for a serial mod-3 divisibility
//   datapath. Two requesters offer W-bit words over valid/ready. One word is
//   granted at a time and shifted out MSB-first, one bit per clock. The
//   running residue is tracked, and a divisible-by-3 verdict is returned on a
//   result handshake. The verdict is tagged with the id of the requester
//   that sent the word.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   reqN_valid/data     requester N word offer (N = 0, 1)
//   reqN_ready          requester N word accepted this edge if valid
//   ser_bit, ser_en     serial bit stream to the datapath, MSB-first
//   res_valid/ready     result handshake
//   res_div3            1 when the accepted word is a multiple of 3
//   res_id              requester that owns the result
//   busy                scheduler is not idle
module mod3_stream_sched #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    input  logic [W-1:0] req0_data,
    output logic         req0_ready,
    input  logic         req1_valid,
    input  logic [W-1:0] req1_data,
    output logic         req1_ready,
    output logic         ser_bit,
    output logic         ser_en,
    output logic         res_valid,
    output logic         res_div3,
    output logic         res_id,
    input  logic         res_ready,
    output logic         busy
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   shreg_q, shreg_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [1:0]     residue_q, residue_d;
    logic           last_id_q, last_id_d;
    logic           res_id_q, res_id_d;
    logic           grant0, grant1;

    // Appending one bit to a number r gives 2r + b, so reduce that mod 3.
    // The unused encoding 3 is treated as residue 0.
    function automatic logic [1:0] residue_step(input logic [1:0] r, input logic b);
        logic [1:0] nxt;
        case (r)
            2'd1:    nxt = b ? 2'd0 : 2'd2;
            2'd2:    nxt = b ? 2'd2 : 2'd1;
            default: nxt = b ? 2'd1 : 2'd0;
        endcase
        return nxt;
    endfunction

    // When both requesters are valid, the one that did not win last time is
    // granted.
    always_comb begin
        grant0 = req0_valid & (~req1_valid | last_id_q);
        grant1 = req1_valid & (~req0_valid | ~last_id_q);
    end

    always_comb begin
        // NOTE: every signal gets a default before the case statement, so no
        // path through this block can leave a latch behind.
        state_d   = state_q;
        shreg_d   = shreg_q;
        cnt_d     = cnt_q;
        residue_d = (residue_q == 2'd3) ? 2'd0 : residue_q;
        last_id_d = last_id_q;
        res_id_d  = res_id_q;

        case (state_q)
            IDLE: begin
                if (grant0 | grant1) begin
                    state_d   = SHIFT;
                    shreg_d   = grant1 ? req1_data : req0_data;
                    res_id_d  = grant1;
                    last_id_d = grant1;
                    residue_d = 2'd0;
                    cnt_d     = '0;
                end
            end
            SHIFT: begin
                residue_d = residue_step(residue_q, shreg_q[W-1]);
                shreg_d   = {shreg_q[W-2:0], 1'b0};
                cnt_d     = cnt_q + CW'(1);
                if (cnt_q == CW'(W - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments only, so every flop
    // samples the values from before the edge regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            cnt_q     <= '0;
            residue_q <= 2'd0;
            last_id_q <= 1'b1;
            res_id_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            cnt_q     <= cnt_d;
            residue_q <= residue_d;
            last_id_q <= last_id_d;
            res_id_q  <= res_id_d;
        end
    end

    always_comb begin
        req0_ready = (state_q == IDLE) & grant0;
        req1_ready = (state_q == IDLE) & grant1;
        ser_en     = (state_q == SHIFT);
        ser_bit    = (state_q == SHIFT) & shreg_q[W-1];
        res_valid  = (state_q == DONE);
        res_div3   = (state_q == DONE) & (residue_q == 2'd0);
        res_id     = res_id_q;
        busy       = (state_q != IDLE);
    end

endmodule

// File: tb/tb_mod3_stream_sched.sv
module tb_mod3_stream_sched;

    logic       clk = 1'b0;
    logic       rst;

    // W = 8 instance
    logic       req0_valid, req1_valid, req0_ready, req1_ready;
    logic [7:0] req0_data, req1_data;
    logic       ser_bit, ser_en, res_valid, res_div3, res_id, res_ready, busy;

    // W = 4 instance
    logic       b_req0_valid, b_req1_valid, b_req0_ready, b_req1_ready;
    logic [3:0] b_req0_data, b_req1_data;
    logic       b_ser_bit, b_ser_en, b_res_valid, b_res_div3, b_res_id, b_res_ready, b_busy;

    int   n_checks = 0;
    int   n_fail   = 0;
    logic m_last;   // reference model: id of the most recent grant

    always #5 clk = ~clk;

    mod3_stream_sched #(.W(8)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .ser_bit(ser_bit), .ser_en(ser_en),
        .res_valid(res_valid), .res_div3(res_div3), .res_id(res_id),
        .res_ready(res_ready), .busy(busy)
    );

    mod3_stream_sched #(.W(4)) dut4 (
        .clk(clk), .rst(rst),
        .req0_valid(b_req0_valid), .req0_data(b_req0_data), .req0_ready(b_req0_ready),
        .req1_valid(b_req1_valid), .req1_data(b_req1_data), .req1_ready(b_req1_ready),
        .ser_bit(b_ser_bit), .ser_en(b_ser_en),
        .res_valid(b_res_valid), .res_div3(b_res_div3), .res_id(b_res_id),
        .res_ready(b_res_ready), .busy(b_busy)
    );

    typedef struct {
        logic       v0;
        logic       v1;
        logic [7:0] d0;
        logic [7:0] d1;
        int         hold;
        logic       exp_id;
        logic       exp_div3;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req0_valid = 0; req1_valid = 0; req0_data = '0; req1_data = '0; res_ready = 0;
        b_req0_valid = 0; b_req1_valid = 0; b_req0_data = '0; b_req1_data = '0; b_res_ready = 0;
        step();
        step();
        rst = 1'b0;
        m_last = 1'b1;
        #1;
        check("rst_busy", busy, 0);
        check("rst_ser_en", ser_en, 0);
        check("rst_ser_bit", ser_bit, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_div3", res_div3, 0);
        check("rst_res_id", res_id, 0);
        check("rst_ready0", req0_ready, 0);
        check("rst_ready1", req1_ready, 0);
    endtask

    // Offer a word, follow it through the serial phase, optionally stall the
    // result for 'hold' cycles, then complete the result handshake.
    task automatic do_word(input logic v0, input logic v1, input logic [7:0] d0,
                           input logic [7:0] d1, input int hold,
                           input logic exp_id, input logic exp_div3);
        logic [7:0] w;
        w = exp_id ? d1 : d0;
        req0_valid = v0; req1_valid = v1; req0_data = d0; req1_data = d1; res_ready = 0;
        #1;
        check("grant_ready0", req0_ready, !exp_id);
        check("grant_ready1", req1_ready, exp_id);
        step();                               // accept edge
        m_last = exp_id;
        req0_valid = 0; req1_valid = 0; req0_data = ~d0; req1_data = ~d1;
        for (int i = 0; i < 8; i++) begin
            check("ser_en", ser_en, 1);
            check("ser_bit", ser_bit, w[7-i]);
            check("early_res_valid", res_valid, 0);
            step();
        end
        check("res_valid", res_valid, 1);
        check("res_div3", res_div3, exp_div3);
        check("res_id", res_id, exp_id);
        for (int h = 0; h < hold; h++) begin
            req0_valid = 1; req1_valid = 1;
            step();
            check("hold_res_valid", res_valid, 1);
            check("hold_res_div3", res_div3, exp_div3);
            check("hold_res_id", res_id, exp_id);
            check("hold_ready0", req0_ready, 0);
            check("hold_ready1", req1_ready, 0);
        end
        req0_valid = 0; req1_valid = 0;
        res_ready = 1;
        step();                               // result handshake edge
        res_ready = 0;
        check("post_busy", busy, 0);
        check("post_res_valid", res_valid, 0);
    endtask

    vec_t vecs[10];
    int   res_cyc[$];
    logic res_ids[$];
    logic res_divs[$];
    logic seen_valid;
    logic [7:0] rd0, rd1;
    logic [1:0] rv;
    logic       rid, rdiv;

    initial begin
        // After reset last grant reads as requester 1, so requester 0 wins
        // the first tie.
        vecs[0] = '{1, 0, 8'h09, 8'h00, 0, 0, 1};
        vecs[1] = '{0, 1, 8'h00, 8'h0A, 0, 1, 0};
        vecs[2] = '{1, 1, 8'hFF, 8'h00, 0, 0, 1};
        vecs[3] = '{1, 1, 8'hFF, 8'h00, 0, 1, 1};
        vecs[4] = '{1, 1, 8'h80, 8'h7F, 0, 0, 0};
        vecs[5] = '{0, 1, 8'h00, 8'h7F, 5, 1, 0};   // backpressure
        vecs[6] = '{1, 1, 8'h03, 8'h06, 0, 0, 1};   // accepted one cycle after release
        vecs[7] = '{1, 0, 8'h01, 8'h00, 0, 0, 0};
        vecs[8] = '{1, 1, 8'h55, 8'hAA, 0, 1, 0};
        vecs[9] = '{0, 1, 8'h00, 8'h0C, 0, 1, 1};

        do_reset();

        for (int k = 0; k < 10; k++) begin
            do_word(vecs[k].v0, vecs[k].v1, vecs[k].d0, vecs[k].d1,
                    vecs[k].hold, vecs[k].exp_id, vecs[k].exp_div3);
        end

        // Fairness: both valid continuously with res_ready high.
        do_reset();
        req0_valid = 1; req1_valid = 1; req0_data = 8'hFF; req1_data = 8'h00; res_ready = 1;
        for (int c = 1; c <= 44; c++) begin
            step();
            if (res_valid) begin
                res_cyc.push_back(c);
                res_ids.push_back(res_id);
                res_divs.push_back(res_div3);
            end
        end
        req0_valid = 0; req1_valid = 0; res_ready = 0;
        check("fair_count", res_cyc.size(), 4);
        for (int k = 0; k < res_cyc.size() && k < 4; k++) begin
            check("fair_id", res_ids[k], k % 2);
            check("fair_div3", res_divs[k], 1);
            if (k > 0) check("fair_spacing", res_cyc[k] - res_cyc[k-1], 10);
        end

        // Reset abort during the 4th serial cycle of 8'h03 from requester 1.
        do_reset();
        req1_valid = 1; req1_data = 8'h03;
        step();                               // accept edge
        req1_valid = 0;
        step(); step(); step();               // now in 4th serial cycle
        check("abort_pre_ser_en", ser_en, 1);
        #2 rst = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_ser_en", ser_en, 0);
        check("abort_ser_bit", ser_bit, 0);
        check("abort_res_valid", res_valid, 0);
        check("abort_res_div3", res_div3, 0);
        check("abort_res_id", res_id, 0);
        step();
        rst = 1'b0;
        m_last = 1'b1;
        seen_valid = 0;
        for (int c = 0; c < 12; c++) begin
            step();
            if (res_valid) seen_valid = 1;
        end
        check("abort_no_result", seen_valid, 0);
        do_word(1, 1, 8'h10, 8'h21, 0, 0, 0);

        // Randomized traffic against the arithmetic reference model.
        for (int k = 0; k < 30; k++) begin
            rv   = 2'($urandom_range(1, 3));
            rd0  = 8'($urandom);
            rd1  = 8'($urandom);
            rid  = (rv[0] && rv[1]) ? ~m_last : rv[1];
            rdiv = ((rid ? rd1 : rd0) % 3) == 0;
            do_word(rv[0], rv[1], rd0, rd1, int'($urandom_range(0, 3)), rid, rdiv);
        end

        // W = 4: 4'hF then 4'hE from requester 0.
        for (int k = 0; k < 2; k++) begin
            b_req0_valid = 1;
            b_req0_data  = (k == 0) ? 4'hF : 4'hE;
            #1;
            check("w4_ready0", b_req0_ready, 1);
            step();                           // accept edge
            b_req0_valid = 0;
            for (int i = 0; i < 4; i++) begin
                check("w4_ser_en", b_ser_en, 1);
                check("w4_early_valid", b_res_valid, 0);
                step();
            end
            check("w4_res_valid", b_res_valid, 1);
            check("w4_res_div3", b_res_div3, (k == 0) ? 1 : 0);
            check("w4_res_id", b_res_id, 0);
            b_res_ready = 1;
            step();
            b_res_ready = 0;
            check("w4_idle", b_busy, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mod3_stream_sched.md
# mod3_stream_sched

Round-robin scheduler and sequencer for the serial mod-3 divisibility datapath. Two requesters present parallel W-bit words over valid/ready handshakes. The block grants one requester at a time and serialises the word MSB-first onto the serial bit interface, one bit per clock. It tracks the running residue and returns a divisible-by-3 verdict tagged with the requester id on a result handshake.

## Interface
- W, 8, word width in bits; legal range 2..32
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset; asynchronous, active-high; one clock domain
- req0_valid  in  1  requester 0 has a word
- req0_data  in  W  requester 0 word, unsigned
- req0_ready  out  1  requester 0 word accepted this edge if valid
- req1_valid  in  1  requester 1 has a word
- req1_data  in  W  requester 1 word, unsigned
- req1_ready  out  1  requester 1 word accepted this edge if valid
- ser_bit  out  1  current serial bit to the datapath, MSB-first
- ser_en  out  1  ser_bit is valid this cycle
- res_valid  out  1  result available
- res_div3  out  1  1 if the accepted word mod 3 == 0
- res_id  out  1  id of the requester that owns the result
- res_ready  in  1  result consumer accepts the result
- busy  out  1  state is not IDLE

## Operation
- State machine states: IDLE, SHIFT, DONE.
- IDLE, grant:
  - One valid requester: that requester is granted.
  - Both valid: the requester not equal to `last_id` is granted.
  - `reqN_ready = (state==IDLE) & grant_N`. Ready may depend combinationally on the other requester's valid.
- IDLE, accept: on valid&ready, capture data into the shift register, `res_id` := granted id, `last_id` := granted id, residue := 0, bit count := 0. Next state is SHIFT.
- SHIFT, each cycle:
  - `ser_en` = 1 and `ser_bit` = shreg[W-1].
  - At the edge: residue := (2·residue + ser_bit) mod 3, using the 2-bit residue encodings 0/1/2. Then shreg shifts left by 1 and count increments.
  - The edge that consumes bit index W-1 (count == W-1) moves to DONE.
- DONE:
  - `res_valid` = 1 and `res_div3` = (residue == 0).
  - `res_id`, `res_div3` and `res_valid` hold stable until res_valid&res_ready, then the next state is IDLE.
- No word is accepted in SHIFT or DONE; both `reqN_ready` are 0 in those states.
- Residue encoding never leaves {0,1,2}. An illegal encoding (3) or illegal state recovers to 0/IDLE.

## Timing
- Reset values:
  - State IDLE, `last_id` = 1, so requester 0 wins the first tie.
  - residue 0, count 0, shreg 0.
  - `res_valid` 0, `res_div3` 0, `res_id` 0, `ser_en` 0, `ser_bit` 0, `busy` 0.
  - Both ready outputs read 0 only while no requester is valid.
- Latency:
  - Accept edge E0. `ser_en` is high for the cycles following edges E0..E0+W-1.
  - `res_valid` rises after edge E0+W, i.e. W cycles after acceptance.
- Throughput: result handshake at edge Ed returns to IDLE. The earliest next acceptance is edge Ed+1, giving W+2 cycles per word with res_ready held high.
- Backpressure: res_ready low holds DONE indefinitely. Requesters see ready=0 throughout.
- Reset mid-operation: rst in SHIFT or DONE aborts immediately (asynchronous).
  - The in-flight word is discarded and no result is produced.
  - All registers return to reset values; arbitration restarts with requester 0 priority.
- Requester data is sampled only at the accept edge. Later changes to data or valid have no effect.

## Test plan
- Single word: W=8, req0 sends 8'h09 -> `ser_bit` is 0,0,0,0,1,0,0,1 over 8 cycles. `res_valid` rises 8 cycles after accept with `res_div3`=1, `res_id`=0.
- Non-multiple: req1 sends 8'h0A -> `res_div3`=0, `res_id`=1. The residue sequence after each bit is 0,0,0,0,1,2,2,1.
- Fairness: both valid continuously (req0=8'hFF, req1=8'h00), res_ready=1 -> grants alternate 0,1,0,1 starting with 0. Every `res_div3`=1, and results are spaced exactly 10 cycles apart.
- Backpressure: hold res_ready=0 for 5 cycles in DONE -> `res_valid`/`res_div3`/`res_id` stable and both ready=0. After release, the next acceptance occurs exactly one cycle later.
- Reset abort: assert rst during the 4th SHIFT cycle of word 8'h03 from req1 -> all outputs return to 0 immediately and no `res_valid` is ever produced. After release with both valid, requester 0 is granted.
- Parameter check: W=4 words 4'hF and 4'hE -> `res_div3`=1 then 0, each 4 cycles after its accept edge.
